// File: rtl/register_file_if.sv
// Register file port bundle: two read ports, one write port.
// Master drives addresses and write data, slave returns read data.
interface register_file_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
);
  logic              we3;
  logic [ADDR_W-1:0] a1;
  logic [ADDR_W-1:0] a2;
  logic [ADDR_W-1:0] a3;
  logic [XLEN-1:0]   wd3;
  logic [XLEN-1:0]   rd1;
  logic [XLEN-1:0]   rd2;

  modport master (
    output we3, a1, a2, a3, wd3,
    input  rd1, rd2
  );

  modport slave (
    input  we3, a1, a2, a3, wd3,
    output rd1, rd2
  );
endinterface

// File: rtl/register_file.sv
// RV32I integer register file: 32 x XLEN, 2 async reads, 1 sync write.
// x0 is hardwired to zero; reads never bypass a same-cycle write.
module register_file #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
) (
  input logic            clk,
  input logic            rst,
  register_file_if.slave bus
);
  localparam int NREGS = 2 ** ADDR_W;

  logic [XLEN-1:0] regs [NREGS];

  // Sync reset clears all; writes to x0 are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.we3 && (bus.a3 != '0)) begin
      regs[bus.a3] <= bus.wd3;
    end
  end

  // Combinational reads; x0 forced to zero from time zero.
  always_comb begin
    bus.rd1 = '0;
    bus.rd2 = '0;
    if (bus.a1 != '0) bus.rd1 = regs[bus.a1];
    if (bus.a2 != '0) bus.rd2 = regs[bus.a2];
  end
endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file.
// Table of directed vectors plus hand-written corner sequences.
module tb_register_file;
  logic clk = 1'b0;
  logic rst = 1'b0;

  register_file_if #(.XLEN(32), .ADDR_W(5)) bus ();

  register_file #(.XLEN(32), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] e1;
    logic [31:0] e2;
    string       name;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      passed++;
  endtask

  task automatic drive(input logic r, input logic we,
                       input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] a3, input logic [31:0] wd);
    rst     = r;
    bus.we3 = we;
    bus.a1  = a1;
    bus.a2  = a2;
    bus.a3  = a3;
    bus.wd3 = wd;
  endtask

  initial begin
    // Expected values reflect state before the edge that follows.
    vecs[0]  = '{1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, "reset"};
    vecs[1]  = '{0, 1, 2, 0, 2, 32'h12345678, 32'h0, 32'h0, "w2_nobypass"};
    vecs[2]  = '{0, 1, 2, 0, 2, 32'h12345678,
                 32'h12345678, 32'h0, "w2_second"};
    vecs[3]  = '{0, 0, 2, 0, 2, 32'h0,
                 32'h12345678, 32'h0, "w2_read"};
    vecs[4]  = '{0, 1, 0, 2, 0, 32'h87654321,
                 32'h0, 32'h12345678, "x0_w1"};
    vecs[5]  = '{0, 1, 0, 2, 0, 32'h87654321,
                 32'h0, 32'h12345678, "x0_w2"};
    vecs[6]  = '{0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, "x0_read"};
    vecs[7]  = '{0, 0, 2, 2, 0, 32'h0,
                 32'h12345678, 32'h12345678, "same_addr"};
    vecs[8]  = '{0, 1, 0, 2, 3, 32'h0000AAAA,
                 32'h0, 32'h12345678, "w3_first"};
    vecs[9]  = '{0, 1, 3, 0, 3, 32'h0000BBBB,
                 32'h0000AAAA, 32'h0, "w3_second"};
    vecs[10] = '{0, 0, 3, 2, 0, 32'h0,
                 32'h0000BBBB, 32'h12345678, "w3_last"};
    vecs[11] = '{0, 0, 3, 3, 3, 32'h0,
                 32'h0000BBBB, 32'h0000BBBB, "w3_hold"};

    drive(0, 0, 0, 0, 0, 32'h0);
    #1;
    check("x0_time_zero_rd1", bus.rd1, 32'h0);
    check("x0_time_zero_rd2", bus.rd2, 32'h0);

    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      drive(vecs[k].rst, vecs[k].we, vecs[k].a1,
            vecs[k].a2, vecs[k].a3, vecs[k].wd);
      #1;
      check({vecs[k].name, "_rd1"}, bus.rd1, vecs[k].e1);
      check({vecs[k].name, "_rd2"}, bus.rd2, vecs[k].e2);
    end

    // Fill 1..31 with their own index.
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      drive(0, 1, 0, 0, 5'(i), 32'(i));
      @(negedge clk);
      drive(0, 0, 5'(i), 5'(i - 1), 0, 32'h0);
      #1;
      check($sformatf("fill_rd1_%0d", i), bus.rd1, 32'(i));
      check($sformatf("fill_rd2_%0d", i), bus.rd2, 32'(i - 1));
    end

    // Disabled write leaves reg 5 untouched.
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      drive(0, 0, 5, 4, 5, 32'hDEADBEEF);
      #1;
      check("we0_rd1", bus.rd1, 32'd5);
      check("we0_rd2", bus.rd2, 32'd4);
    end

    // Same-cycle read of the written register sees old value.
    @(negedge clk);
    drive(0, 1, 7, 7, 7, 32'hA5A5A5A5);
    #1;
    check("bypass_old_rd1", bus.rd1, 32'd7);
    check("bypass_old_rd2", bus.rd2, 32'd7);
    @(posedge clk);
    #1;
    check("bypass_new_rd1", bus.rd1, 32'hA5A5A5A5);
    check("bypass_new_rd2", bus.rd2, 32'hA5A5A5A5);

    // Reset with a simultaneous write; no async effect first.
    @(negedge clk);
    drive(1, 1, 9, 8, 9, 32'hFFFFFFFF);
    #1;
    check("rst_noasync_rd1", bus.rd1, 32'd9);
    check("rst_noasync_rd2", bus.rd2, 32'd8);
    @(posedge clk);
    #1;
    drive(0, 0, 9, 9, 0, 32'h0);
    #1;
    check("rst_over_write", bus.rd1, 32'h0);
    for (int i = 0; i < 32; i++) begin
      bus.a1 = 5'(i);
      bus.a2 = 5'(31 - i);
      #1;
      check($sformatf("rst_clear_rd1_%0d", i), bus.rd1, 32'h0);
      check($sformatf("rst_clear_rd2_%0d", i), bus.rd2, 32'h0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
